// File: rtl/pkt_stream_pkg.sv
// Shared types and helpers for the packet stream decoder: FSM state codes,
// default start-of-packet marker and command length table lookup.
package pkt_stream_pkg;

  localparam logic [7:0] DEFAULT_HEADER = 8'hF5;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_CMD      = 3'd1;
  localparam state_t ST_PAYLOAD  = 3'd2;
  localparam state_t ST_CHECK    = 3'd3;
  localparam state_t ST_COMPLETE = 3'd4;

  // Widest length table the lookup helper accepts.
  localparam int unsigned LEN_TABLE_MAX_W = 256;

  // Payload length of command idx from a packed table of len_w-bit entries.
  function automatic int unsigned cmd_len(input logic [LEN_TABLE_MAX_W-1:0] table_bits,
                                          input int unsigned idx,
                                          input int unsigned len_w);
    logic [LEN_TABLE_MAX_W-1:0] shifted;
    shifted = table_bits >> (idx * len_w);
    return 32'(shifted) & ((32'd1 << len_w) - 32'd1);
  endfunction

endpackage

// File: rtl/pkt_timeout_timer.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags the cycle in which the LIMIT-th idle cycle completes (LIMIT=0: never).
module pkt_timeout_timer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LIMIT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [WIDTH-1:0] count;

  assign expired_c = (LIMIT != 0) && enable && !clear && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !enable || expired_c) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pkt_stream_decoder.sv
// Header/command/payload packet decoder with valid/ready output, inter-byte
// timeout and error pulses. Define PKT_CHECKSUM_EN for a trailing XOR check byte.
module pkt_stream_decoder
  import pkt_stream_pkg::*;
#(
  parameter logic [7:0]  HEADER_BYTE  = DEFAULT_HEADER,
  parameter int unsigned NUM_CMDS     = 4,
  parameter int unsigned MAX_PAYLOAD  = 4,
  localparam int unsigned LEN_W       = $clog2(MAX_PAYLOAD + 1),
  parameter logic [NUM_CMDS*LEN_W-1:0] CMD_LEN_TABLE = {3'd4, 3'd2, 3'd1, 3'd0},
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                     i_clk,
  input  logic                     n_btn_rst,
  input  logic                     i_rx_stb,
  input  logic [7:0]               i_rx_byte,
  input  logic                     i_rx_err,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [7:0]               o_cmd,
  output logic [MAX_PAYLOAD*8-1:0] o_data,
  output logic [LEN_W-1:0]         o_len,
  output logic                     o_err_cmd,
  output logic                     o_err_rx,
  output logic                     o_err_timeout,
`ifdef PKT_CHECKSUM_EN
  output logic                     o_err_chk,
`endif
  output logic                     o_overrun
);

  localparam int unsigned DATA_W = MAX_PAYLOAD * 8;

`ifdef PKT_CHECKSUM_EN
  localparam state_t AFTER_DATA = ST_CHECK;
`else
  localparam state_t AFTER_DATA = ST_COMPLETE;
`endif

  state_t             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  buf_q, buf_d;

  logic               valid_d;
  logic [7:0]         out_cmd_d;
  logic [DATA_W-1:0]  out_data_d;
  logic [LEN_W-1:0]   out_len_d;
  logic               err_cmd_d, err_rx_d, err_timeout_d, overrun_d;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
  logic               err_chk_d;
`endif

  logic               good_c, bad_c, waiting_c, expired_c;
  logic [LEN_W-1:0]   new_len_c;

  assign good_c    = i_rx_stb && !i_rx_err;
  assign bad_c     = i_rx_stb && i_rx_err;
  assign waiting_c = (state_q == ST_CMD) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
  assign new_len_c = LEN_W'(cmd_len(LEN_TABLE_MAX_W'(CMD_LEN_TABLE), 32'(i_rx_byte), LEN_W));

  // Idle time only accrues while a packet is partially received.
  pkt_timeout_timer #(
    .WIDTH (16),
    .LIMIT (32'(TIMEOUT_CYCLES))
  ) u_timer (
    .clk       (i_clk),
    .rst_n     (n_btn_rst),
    .clear     (i_rx_stb),
    .enable    (waiting_c),
    .expired_c (expired_c)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    valid_d       = o_valid && !i_ready;
    out_cmd_d     = o_cmd;
    out_data_d    = o_data;
    out_len_d     = o_len;
    err_cmd_d     = 1'b0;
    err_rx_d      = 1'b0;
    err_timeout_d = 1'b0;
    overrun_d     = 1'b0;
`ifdef PKT_CHECKSUM_EN
    sum_d         = sum_q;
    err_chk_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (good_c && (i_rx_byte == HEADER_BYTE)) state_d = ST_CMD;
      end

      ST_CMD, ST_PAYLOAD, ST_CHECK: begin
        if (bad_c) begin
          err_rx_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (expired_c) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (good_c) begin
          if (state_q == ST_CMD) begin
            if (32'(i_rx_byte) >= NUM_CMDS) begin
              err_cmd_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              cmd_d   = i_rx_byte;
              len_d   = new_len_c;
              cnt_d   = '0;
              buf_d   = '0;
`ifdef PKT_CHECKSUM_EN
              sum_d   = i_rx_byte;
`endif
              state_d = (new_len_c == '0) ? AFTER_DATA : ST_PAYLOAD;
            end
          end else if (state_q == ST_PAYLOAD) begin
            for (int unsigned k = 0; k < MAX_PAYLOAD; k++) begin
              if (cnt_q == LEN_W'(k)) buf_d[8*k +: 8] = i_rx_byte;
            end
            cnt_d = cnt_q + LEN_W'(1);
`ifdef PKT_CHECKSUM_EN
            sum_d = sum_q ^ i_rx_byte;
`endif
            if (cnt_d == len_q) state_d = AFTER_DATA;
          end else begin
`ifdef PKT_CHECKSUM_EN
            if (i_rx_byte == sum_q) begin
              state_d = ST_COMPLETE;
            end else begin
              err_chk_d = 1'b1;
              state_d   = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end

      // A held, unaccepted packet wins over the new one.
      ST_COMPLETE: begin
        if (!o_valid || i_ready) begin
          valid_d    = 1'b1;
          out_cmd_d  = cmd_q;
          out_data_d = buf_q;
          out_len_d  = len_q;
        end else begin
          overrun_d = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      buf_q         <= '0;
      o_valid       <= 1'b0;
      o_cmd         <= '0;
      o_data        <= '0;
      o_len         <= '0;
      o_err_cmd     <= 1'b0;
      o_err_rx      <= 1'b0;
      o_err_timeout <= 1'b0;
      o_overrun     <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      sum_q         <= '0;
      o_err_chk     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      buf_q         <= buf_d;
      o_valid       <= valid_d;
      o_cmd         <= out_cmd_d;
      o_data        <= out_data_d;
      o_len         <= out_len_d;
      o_err_cmd     <= err_cmd_d;
      o_err_rx      <= err_rx_d;
      o_err_timeout <= err_timeout_d;
      o_overrun     <= overrun_d;
`ifdef PKT_CHECKSUM_EN
      sum_q         <= sum_d;
      o_err_chk     <= err_chk_d;
`endif
    end
  end

endmodule
